// File: rtl/t2mi_pkg.sv
// Shared definitions for the T2-MI packer: scheduler states, BB header length
// and the widths of the per-frame fields.
package t2mi_pkg;

    localparam int T2MI_BBHDR_BITS = 80;
    localparam int PLP_ID_W        = 8;
    localparam int BLOCK_CNT_W     = 10;
    localparam int FRAME_IDX_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BBF_REQ,
        S_BBF_WAIT,
        S_L1_REQ,
        S_L1_WAIT,
        S_ADVANCE
    } sched_state_t;

endpackage

// File: rtl/t2mi_bbf_scheduler.sv
// Per-T2-frame sequencer: latches L1 parameters on a frame tick, requests one
// BB frame per FEC block, then one L1-current packet, then advances indices.
module t2mi_bbf_scheduler
    import t2mi_pkg::*;
#(
    parameter int BBHDR_BITS = T2MI_BBHDR_BITS,
    parameter int SF_IDX_W   = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   FRAME_TICK,
    input  logic [PLP_ID_W-1:0]    plp_id,
    input  logic                   nm_or_hem,
    input  logic [BLOCK_CNT_W-1:0] plp_num_blocks,
    input  logic [FRAME_IDX_W-1:0] num_t2_frames,
    input  logic [15:0]            k_bch,
    input  logic                   BBF_READY,
    input  logic                   BBF_DONE,
    input  logic                   L1_READY,
    input  logic                   L1_DONE,
    output logic                   BBF_START,
    output logic                   BBF_FIRST,
    output logic [15:0]            BBF_DFL,
    output logic [PLP_ID_W-1:0]    BBF_PLP_ID,
    output logic                   BBF_MODE,
    output logic                   L1_START,
    output logic [FRAME_IDX_W-1:0] FRAME_IDX,
    output logic [SF_IDX_W-1:0]    SF_IDX,
    output logic [BLOCK_CNT_W-1:0] BLOCK_CNT,
    output logic                   BUSY,
    output logic                   OVERRUN
);

    sched_state_t           state;
    logic [BLOCK_CNT_W-1:0] num_blocks;
    logic [FRAME_IDX_W-1:0] num_frames;
    logic [BLOCK_CNT_W-1:0] next_block_cnt;
    logic                   frame_wrap;

    assign next_block_cnt = BLOCK_CNT + BLOCK_CNT_W'(1);

    // Widened by one bit so a frame count of 255 cannot alias to zero.
    assign frame_wrap = ({1'b0, FRAME_IDX} + 9'd1) >= {1'b0, num_frames};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            num_blocks <= '0;
            num_frames <= '0;
            BBF_START  <= 1'b0;
            BBF_FIRST  <= 1'b0;
            BBF_DFL    <= '0;
            BBF_PLP_ID <= '0;
            BBF_MODE   <= 1'b0;
            L1_START   <= 1'b0;
            FRAME_IDX  <= '0;
            SF_IDX     <= '0;
            BLOCK_CNT  <= '0;
            BUSY       <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            // A tick arriving mid-frame is dropped, only remembered here.
            if (FRAME_TICK && state != S_IDLE) begin
                OVERRUN <= 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    if (FRAME_TICK) begin
                        BBF_PLP_ID <= plp_id;
                        BBF_MODE   <= nm_or_hem;
                        num_blocks <= plp_num_blocks;
                        num_frames <= num_t2_frames;
                        BBF_DFL    <= k_bch - 16'(BBHDR_BITS);
                        BLOCK_CNT  <= '0;
                        BUSY       <= 1'b1;
                        if (plp_num_blocks == '0) begin
                            state    <= S_L1_REQ;
                            L1_START <= 1'b1;
                        end else begin
                            state     <= S_BBF_REQ;
                            BBF_START <= 1'b1;
                            BBF_FIRST <= 1'b1;
                        end
                    end
                end
                S_BBF_REQ: begin
                    if (BBF_READY) begin
                        BBF_START <= 1'b0;
                        BBF_FIRST <= 1'b0;
                        state     <= S_BBF_WAIT;
                    end
                end
                S_BBF_WAIT: begin
                    if (BBF_DONE) begin
                        BLOCK_CNT <= next_block_cnt;
                        if (next_block_cnt == num_blocks) begin
                            state    <= S_L1_REQ;
                            L1_START <= 1'b1;
                        end else begin
                            state     <= S_BBF_REQ;
                            BBF_START <= 1'b1;
                            BBF_FIRST <= 1'b0;
                        end
                    end
                end
                S_L1_REQ: begin
                    if (L1_READY) begin
                        L1_START <= 1'b0;
                        state    <= S_L1_WAIT;
                    end
                end
                S_L1_WAIT: begin
                    if (L1_DONE) begin
                        state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (frame_wrap) begin
                        FRAME_IDX <= '0;
                        SF_IDX    <= SF_IDX + SF_IDX_W'(1);
                    end else begin
                        FRAME_IDX <= FRAME_IDX + FRAME_IDX_W'(1);
                    end
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/t2mi_bbf_scheduler.md
# t2mi_bbf_scheduler

Per-T2-frame sequencer for the T2-MI packer. On every T2 frame tick it latches the decoded L1 parameters (PLP id, mode, FEC blocks per frame, frames per superframe, K_bch). It then issues one BB-frame build request per FEC block to the BB-frame/packet builder, followed by one L1-current packet request. Finally it advances the frame and superframe indices that feed the T2-MI headers. It sits between the L1 parameter decoder and the packet builders.

## Interface
Parameters:
- BBHDR_BITS, 80: BB header length in bits, subtracted from K_bch to form DFL.
- SF_IDX_W, 4: superframe index width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- FRAME_TICK  in  1  one-cycle pulse marking the start of a T2 frame.
- plp_id  in  8  PLP id from the L1 decoder.
- nm_or_hem  in  1  0 = NM, 1 = HEM.
- plp_num_blocks  in  10  FEC blocks per T2 frame.
- num_t2_frames  in  8  T2 frames per superframe.
- k_bch  in  16  BCH information bits per FEC block.
- BBF_READY  in  1  BB-frame builder can accept a request.
- BBF_DONE  in  1  one-cycle pulse: requested BB frame fully emitted.
- L1_READY  in  1  L1 packet builder can accept a request.
- L1_DONE  in  1  one-cycle pulse: L1-current packet fully emitted.
- BBF_START  out  1  BB-frame request valid.
- BBF_FIRST  out  1  qualifies BBF_START: first block of this T2 frame.
- BBF_DFL  out  16  k_bch − BBHDR_BITS (latched).
- BBF_PLP_ID  out  8  latched plp_id.
- BBF_MODE  out  1  latched nm_or_hem.
- L1_START  out  1  L1-current request valid.
- FRAME_IDX  out  8  frame index within superframe.
- SF_IDX  out  SF_IDX_W  superframe index.
- BLOCK_CNT  out  10  blocks completed in the current frame.
- BUSY  out  1  high in every state except IDLE.
- OVERRUN  out  1  sticky: a tick arrived while BUSY.

## Operation
- States: IDLE, BBF_REQ, BBF_WAIT, L1_REQ, L1_WAIT, ADVANCE.
- IDLE + FRAME_TICK:
  - Latch plp_id, nm_or_hem, plp_num_blocks, num_t2_frames, and DFL = k_bch − BBHDR_BITS.
  - Clear BLOCK_CNT.
  - Go to BBF_REQ, or to L1_REQ if plp_num_blocks = 0.
- BBF_REQ:
  - BBF_START = 1.
  - BBF_FIRST = 1 when BLOCK_CNT = 0.
  - Transfer occurs when BBF_START & BBF_READY; then go to BBF_WAIT.
- BBF_WAIT, on BBF_DONE:
  - BLOCK_CNT += 1.
  - If the new count equals the latched block count, go to L1_REQ; else go to BBF_REQ.
- L1_REQ: L1_START = 1. On L1_READY go to L1_WAIT.
- L1_WAIT: on L1_DONE go to ADVANCE.
- ADVANCE (one cycle):
  - If FRAME_IDX + 1 ≥ latched num_t2_frames: FRAME_IDX ← 0 and SF_IDX += 1, wrapping modulo 2^SF_IDX_W.
  - Else FRAME_IDX += 1.
  - num_t2_frames of 0 or 1 therefore wraps every frame.
  - Go to IDLE.
- FRAME_TICK outside IDLE is ignored (the frame is dropped) and sets OVERRUN. OVERRUN clears only on RST.
- Latched outputs stay stable from latch until the next latch. Live input changes mid-frame have no effect.
- DONE pulses outside their WAIT state are ignored.
- DFL arithmetic is 16-bit unsigned. k_bch < 80 wraps; no check is made, because the decoder supplies only legal values.

## Timing
- Reset values: state IDLE; all outputs 0, including FRAME_IDX, SF_IDX, BLOCK_CNT, OVERRUN and the latched fields.
- RST mid-operation aborts the sequence immediately; no further START is issued.
- Tick at edge k: BBF_START (or L1_START) is high in cycle k+1.
- START is held until accepted (READY high at an edge). It drops the cycle after acceptance.
- START never re-asserts before the matching DONE.
- READY and DONE in the same cycle as acceptance: DONE is not counted, because the state is still *_REQ.
- L1_DONE at edge m → ADVANCE during m+1 → FRAME_IDX updated and BUSY low from m+2.
- The earliest next tick accepted is at edge m+2.

## Structure
- Shared package t2mi_pkg holds:
  - the state enumeration;
  - the BBHDR_BITS constant (80);
  - the field widths: PLP id 8, block count 10, frame index 8.
- Single flat module; no sub-module is warranted. The index/wrap logic is an inline counter.

## Test plan
- Basic frame: plp_num_blocks = 3, k_bch = 7032, num_t2_frames = 2, READY tied high, DONE 5 cycles after each accept.
  - Exactly 3 BBF_START accepts, BBF_FIRST on the first only, BBF_DFL = 6952.
  - Then 1 L1_START; FRAME_IDX goes 0 → 1.
- Superframe wrap: num_t2_frames = 2, three ticks → FRAME_IDX 0, 1, 0 and SF_IDX 0, 0, 1. SF_IDX wraps 15 → 0 after 16 superframes.
- Backpressure: BBF_READY low for 10 cycles → BBF_START held steady for 10 cycles, with no DONE counted. BBF_DONE injected during BBF_REQ is ignored, and BLOCK_CNT is unchanged.
- Zero blocks: plp_num_blocks = 0 → no BBF_START; L1_START appears the cycle after the tick.
- Overrun: second FRAME_TICK during BBF_WAIT → OVERRUN = 1 and sticky. The current frame completes normally, with no extra frame.
- Reset mid-frame: RST asserted in BBF_WAIT after 1 block → next cycle all outputs are 0 and the state is IDLE. A following tick restarts with BBF_FIRST = 1 and FRAME_IDX = 0.
